// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-beat command/response client to APB initiator, with
//            slave wait-state support and an ACCESS-phase watchdog.
// Revision : 1.0 - initial release
// ============================================================================

module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the edge that would complete the TIMEOUT-th waiting cycle
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_done;
    logic                w_tout;
    logic                w_wait_exp;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;

    assign w_wait_exp = (TIMEOUT != 0) && (r_wait == c_WAIT_LAST);

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // A completing slave wins over an expiring watchdog
                if (pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_wait_exp) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_wait        <= '0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait   <= '0;
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_write ? cmd_wdata : '0;
            end
            if (r_state == S_ACCESS && !pready && !w_wait_exp) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                r_rsp_err     <= pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_tout) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign penable     = (r_state == S_ACCESS);
    assign rsp_valid   = (r_state == S_RESP);
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

`default_nettype wire
